// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/pc-inc over a req/ack memory port; 4 cycles ALU/LDI/NOP, 5 LD/ST, 3 JMP at 1-cycle ack.
// Memory backpressure: FETCH and MEM hold mem_req until mem_ack; reset kills all strobes combinationally.
module cpu_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0100,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      pc,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic [3:0]       rf_sel0,
    output logic [3:0]       rf_sel1,
    output logic [3:0]       rf_write_address,
    output logic             rf_write_en,
    output logic [1:0]       rf_data_sel,
    output logic [3:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic             retired,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_PC_INC, S_HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] R_PC    = 4'hF;

    state_t      state, state_nxt;
    logic [15:0] ir;
    logic [3:0]  op, rd;
    logic        fsm_req, fsm_we, fsm_wen, fsm_ret, fsm_ill;

    // PC is owned by the regfile; the sequencer only steers writes to r15.
    logic unused_pc;
    assign unused_pc = ^{pc, RESET_PC};

    assign op      = ir[15:12];
    assign rd      = ir[11:8];
    assign rf_sel0 = ir[7:4];
    assign rf_sel1 = ir[3:0];

    assign mem_req     = fsm_req & ~reset;
    assign mem_we      = fsm_we  & ~reset;
    assign rf_write_en = fsm_wen & ~reset;
    assign retired     = fsm_ret & ~reset;
    assign illegal     = fsm_ill & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FETCH;
            ir           <= '0;
            retire_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && mem_ack)
                ir <= mem_rdata;
            if (fsm_ret)
                retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_nxt        = state;
        fsm_req          = 1'b0;
        fsm_we           = 1'b0;
        fsm_wen          = 1'b0;
        fsm_ret          = 1'b0;
        fsm_ill          = 1'b0;
        mem_addr_sel     = 1'b0;
        rf_write_address = rd;
        rf_data_sel      = 2'd0;
        alu_op           = op;
        halted           = 1'b0;
        case (state)
            S_FETCH: begin
                fsm_req = 1'b1;
                if (mem_ack)
                    state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, OP_LDI: begin
                        fsm_wen     = 1'b1;
                        rf_data_sel = (op == OP_LDI) ? 2'd3 : 2'd0;
                        // A write straight into r15 is a jump: skip the increment.
                        if (rd == R_PC) begin
                            fsm_ret   = 1'b1;
                            state_nxt = S_FETCH;
                        end else begin
                            state_nxt = S_PC_INC;
                        end
                    end
                    OP_LD, OP_ST: state_nxt = S_MEM;
                    OP_JMP: begin
                        fsm_wen          = 1'b1;
                        rf_write_address = R_PC;
                        rf_data_sel      = 2'd0;
                        alu_op           = 4'hF;
                        fsm_ret          = 1'b1;
                        state_nxt        = S_FETCH;
                    end
                    OP_HALT: begin
                        fsm_ret   = 1'b1;
                        state_nxt = S_HALT;
                    end
                    4'hB, 4'hD, 4'hE: begin
                        fsm_ill   = 1'b1;
                        state_nxt = S_PC_INC;
                    end
                    default: state_nxt = S_PC_INC;
                endcase
            end
            S_MEM: begin
                fsm_req      = 1'b1;
                mem_addr_sel = 1'b1;
                fsm_we       = (op == OP_ST);
                if (mem_ack) begin
                    if (op == OP_LD) begin
                        fsm_wen     = 1'b1;
                        rf_data_sel = 2'd1;
                        if (rd == R_PC) begin
                            fsm_ret   = 1'b1;
                            state_nxt = S_FETCH;
                        end else begin
                            state_nxt = S_PC_INC;
                        end
                    end else begin
                        state_nxt = S_PC_INC;
                    end
                end
            end
            S_PC_INC: begin
                fsm_wen          = 1'b1;
                rf_write_address = R_PC;
                rf_data_sel      = 2'd2;
                fsm_ret          = 1'b1;
                state_nxt        = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_nxt = S_FETCH;
        endcase
    end

endmodule
